// File: rtl/user_gpio_in_filter.sv
// -----------------------------------------------------------------------------
// user_gpio_in_filter
//
// Input-conditioning stage for the user GPIO block. Each raw pad bit passes
// through a two-flop synchronizer and then an optional glitch filter. The
// filter is evaluated on a shared prescaled sample tick. After the filter,
// each bit has rise/fall edge detection and a sticky interrupt status bit that
// software clears by writing 1.
//
// Parameters:
//   GPIO_NUM    number of GPIO bits
//   DIV_W       prescaler divider width
//
// Ports:
//   clk_i        system clock
//   rst_n_i      asynchronous active-low reset
//   gpio_in_i    raw pad input, asynchronous to clk_i
//   filt_en_i    per-bit filter enable (0 = bypass)
//   filt_div_i   sample tick every filt_div_i+1 cycles
//   filt_len_i   consecutive differing samples needed to change level (0 -> 1)
//   rise_en_i    per-bit rising-edge status enable
//   fall_en_i    per-bit falling-edge status enable
//   stat_clr_i   one-cycle write-1-to-clear pulse for status
//   gpio_sync_o  synchronized level (second sync flop)
//   gpio_filt_o  filtered level, feeds the DI register
//   stat_o       sticky edge status
//   irq_o        OR of stat_o
// -----------------------------------------------------------------------------
module user_gpio_in_filter #(
    parameter int GPIO_NUM = 8,
    parameter int DIV_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [GPIO_NUM-1:0] gpio_in_i,
    input  logic [GPIO_NUM-1:0] filt_en_i,
    input  logic [DIV_W-1:0]    filt_div_i,
    input  logic [3:0]          filt_len_i,
    input  logic [GPIO_NUM-1:0] rise_en_i,
    input  logic [GPIO_NUM-1:0] fall_en_i,
    input  logic [GPIO_NUM-1:0] stat_clr_i,
    output logic [GPIO_NUM-1:0] gpio_sync_o,
    output logic [GPIO_NUM-1:0] gpio_filt_o,
    output logic [GPIO_NUM-1:0] stat_o,
    output logic                irq_o
);

    logic [GPIO_NUM-1:0] sync1;
    logic [GPIO_NUM-1:0] sync2;
    logic [DIV_W-1:0]    cnt;
    logic                tick;
    logic [3:0]          scnt [GPIO_NUM];
    logic [GPIO_NUM-1:0] filt;
    logic [GPIO_NUM-1:0] filt_prev;
    logic [GPIO_NUM-1:0] stat;
    logic [GPIO_NUM-1:0] rise;
    logic [GPIO_NUM-1:0] fall;
    logic [GPIO_NUM-1:0] set;
    logic [4:0]          len_eff;

    // ------------------------------------------------------------------
    // Two-flop synchronizer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= gpio_in_i;
            sync2 <= sync1;
        end
    end

    // ------------------------------------------------------------------
    // Prescaler. Using >= rather than == means a divider lowered below the
    // running count ticks on the next cycle instead of wrapping the counter.
    // ------------------------------------------------------------------
    assign tick = (cnt >= filt_div_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Glitch filter. The stable counter restarts on any sample that agrees
    // with the current level, so only an unbroken run of len_eff differing
    // samples moves the output. Widened to 5 bits so scnt+1 cannot wrap.
    // ------------------------------------------------------------------
    assign len_eff = (filt_len_i == 4'd0) ? 5'd1 : {1'b0, filt_len_i};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            filt <= '0;
            for (int unsigned i = 0; i < GPIO_NUM; i++) begin
                scnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < GPIO_NUM; i++) begin
                if (!filt_en_i[i]) begin
                    // bypass: follow the synchronizer, drop any partial count
                    filt[i] <= sync2[i];
                    scnt[i] <= '0;
                end else if (tick) begin
                    if (sync2[i] == filt[i]) begin
                        scnt[i] <= '0;
                    end else if (({1'b0, scnt[i]} + 5'd1) >= len_eff) begin
                        filt[i] <= sync2[i];
                        scnt[i] <= '0;
                    end else begin
                        scnt[i] <= scnt[i] + 4'd1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Edge detection and sticky status. Set wins over a simultaneous clear
    // so an edge arriving during a software clear is never lost.
    // ------------------------------------------------------------------
    assign rise = filt & ~filt_prev;
    assign fall = ~filt & filt_prev;
    assign set  = (rise & rise_en_i) | (fall & fall_en_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            filt_prev <= '0;
            stat      <= '0;
        end else begin
            filt_prev <= filt;
            stat      <= set | (stat & ~stat_clr_i);
        end
    end

    assign gpio_sync_o = sync2;
    assign gpio_filt_o = filt;
    assign stat_o      = stat;
    assign irq_o       = |stat;

endmodule

// File: tb/tb_user_gpio_in_filter.sv
module tb_user_gpio_in_filter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  gpio_in;
    logic [7:0]  filt_en;
    logic [15:0] filt_div;
    logic [3:0]  filt_len;
    logic [7:0]  rise_en;
    logic [7:0]  fall_en;
    logic [7:0]  stat_clr;
    logic [7:0]  gpio_sync;
    logic [7:0]  gpio_filt;
    logic [7:0]  stat;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    user_gpio_in_filter #(.GPIO_NUM(8), .DIV_W(16)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .gpio_in_i   (gpio_in),
        .filt_en_i   (filt_en),
        .filt_div_i  (filt_div),
        .filt_len_i  (filt_len),
        .rise_en_i   (rise_en),
        .fall_en_i   (fall_en),
        .stat_clr_i  (stat_clr),
        .gpio_sync_o (gpio_sync),
        .gpio_filt_o (gpio_filt),
        .stat_o      (stat),
        .irq_o       (irq)
    );

    // ------------------------------------------------------------------
    // Reference model: pin history delayed two clocks, a "cycles since last
    // sample" counter, and per bit the length of the current run of samples
    // that disagree with the accepted level.
    // ------------------------------------------------------------------
    logic [7:0] m_pin_d1, m_pin_d2;
    logic [7:0] m_level, m_level_old, m_stat;
    int         m_since;
    int         m_run [8];
    int         m_need;
    bit         m_sample;
    logic [7:0] m_new_level;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pin_d1 = 8'h00; m_pin_d2 = 8'h00;
            m_level = 8'h00; m_level_old = 8'h00; m_stat = 8'h00;
            m_since = 0;
            for (int b = 0; b < 8; b++) m_run[b] = 0;
        end else begin
            m_sample = (m_since >= int'(filt_div));
            m_need   = (filt_len == 4'd0) ? 1 : int'(filt_len);
            // status from the edge seen between the last two accepted levels
            for (int b = 0; b < 8; b++) begin
                if ((m_level[b] && !m_level_old[b] && rise_en[b]) ||
                    (!m_level[b] && m_level_old[b] && fall_en[b]))
                    m_stat[b] = 1'b1;
                else if (stat_clr[b])
                    m_stat[b] = 1'b0;
            end
            m_new_level = m_level;
            for (int b = 0; b < 8; b++) begin
                if (!filt_en[b]) begin
                    m_new_level[b] = m_pin_d2[b];
                    m_run[b] = 0;
                end else if (m_sample) begin
                    if (m_pin_d2[b] == m_level[b]) m_run[b] = 0;
                    else if (m_run[b] + 1 >= m_need) begin
                        m_new_level[b] = m_pin_d2[b];
                        m_run[b] = 0;
                    end else m_run[b] = m_run[b] + 1;
                end
            end
            m_level_old = m_level;
            m_level     = m_new_level;
            m_pin_d2    = m_pin_d1;
            m_pin_d1    = gpio_in;
            m_since     = m_sample ? 0 : m_since + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // every-cycle comparison against the model
    always @(negedge clk) begin
        chk("model_sync", 32'(gpio_sync), 32'(m_pin_d2));
        chk("model_filt", 32'(gpio_filt), 32'(m_level));
        chk("model_stat", 32'(stat), 32'(m_stat));
        chk("model_irq",  32'(irq), 32'(|m_stat));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; gpio_in = 8'h00; filt_en = 8'h00; filt_div = 16'd0;
        filt_len = 4'd0; rise_en = 8'h00; fall_en = 8'h00; stat_clr = 8'h00;
        cyc(3);
        chk("reset_filt", 32'(gpio_filt), 32'h0);
        rst_n = 1'b1;
        cyc(2);
        chk("post_reset_sync", 32'(gpio_sync), 32'h0);
        chk("post_reset_stat", 32'(stat), 32'h0);

        // bypass latency
        gpio_in = 8'h01;
        cyc(1);
        chk("lat1_sync", 32'(gpio_sync), 32'h00);
        cyc(1);
        chk("lat2_sync", 32'(gpio_sync), 32'h01);
        chk("lat2_filt", 32'(gpio_filt), 32'h00);
        cyc(1);
        chk("lat3_filt", 32'(gpio_filt), 32'h01);
        chk("lat3_irq",  32'(irq), 32'h0);

        // rising-edge status, clear, fall not enabled
        gpio_in = 8'h00;
        cyc(6);
        rise_en = 8'h01;
        gpio_in = 8'h01;
        cyc(3);
        chk("rise3_stat", 32'(stat), 32'h00);
        cyc(1);
        chk("rise4_stat", 32'(stat), 32'h01);
        chk("rise4_irq",  32'(irq), 32'h1);
        stat_clr = 8'h01;
        cyc(1);
        stat_clr = 8'h00;
        chk("clr_stat", 32'(stat), 32'h00);
        gpio_in = 8'h00;
        cyc(6);
        chk("fall_no_stat", 32'(stat), 32'h00);

        // glitch filter: div=3, len=4
        filt_en = 8'h01; filt_div = 16'd3; filt_len = 4'd4;
        cyc(20);
        gpio_in = 8'h01;
        cyc(12);
        gpio_in = 8'h00;
        cyc(30);
        chk("glitch_rejected", 32'(gpio_filt), 32'h00);
        gpio_in = 8'h01;
        cyc(14);
        chk("filt_not_yet", 32'(gpio_filt), 32'h00);
        cyc(8);
        chk("filt_accepted", 32'(gpio_filt), 32'h01);

        // len 0 treated as 1, div 0 -> bypass-like latency
        filt_len = 4'd0; filt_div = 16'd0;
        gpio_in = 8'h00;
        cyc(10);
        gpio_in = 8'h01;
        cyc(2);
        chk("len0_lat2", 32'(gpio_filt), 32'h00);
        cyc(1);
        chk("len0_lat3", 32'(gpio_filt), 32'h01);

        // fall status with simultaneous clear on bit1
        fall_en = 8'h02;
        gpio_in = 8'h03;
        cyc(8);
        stat_clr = 8'hff;
        cyc(1);
        stat_clr = 8'h00;
        chk("pre_fall_stat", 32'(stat), 32'h00);
        gpio_in = 8'h01;
        cyc(3);
        stat_clr = 8'h02;
        cyc(1);
        stat_clr = 8'h00;
        chk("set_beats_clr", 32'(stat), 32'h02);
        chk("set_beats_clr_irq", 32'(irq), 32'h1);
        stat_clr = 8'hff;
        cyc(1);
        stat_clr = 8'h00;

        // divider lowered below running count
        filt_len = 4'd1; filt_div = 16'd1000;
        cyc(500);
        gpio_in = 8'h00;
        cyc(5);
        chk("div1000_hold", 32'(gpio_filt), 32'h01);
        filt_div = 16'd10;
        cyc(1);
        chk("div_lowered_tick", 32'(gpio_filt), 32'h00);
        gpio_in = 8'h01;
        cyc(10);
        chk("div10_wait", 32'(gpio_filt), 32'h00);
        cyc(1);
        chk("div10_tick", 32'(gpio_filt), 32'h01);

        // asynchronous reset mid-count, pin held high through reset
        gpio_in = 8'h00;
        cyc(4);
        gpio_in = 8'h01;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_filt", 32'(gpio_filt), 32'h00);
        chk("async_rst_sync", 32'(gpio_sync), 32'h00);
        chk("async_rst_irq",  32'(irq), 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(30);
        chk("held_high_rise", 32'(stat), 32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
